fcmp_pipe: RTL and testbench

Two-stage pipelined single-precision compare unit (feq/flt/fle) with valid/ready handshakes on both sides. It sits between FPU issue and integer writeback. It accepts one operation per cycle, carries a destination tag, and returns a 32-bit 0/1 result destined for an integer register. Compare semantics follow the FPU's existing le convention: sign-magnitude ordering, +0 equal to -0, NaN not special-cased (the FPU never produces NaN).

---
 rtl/fpu_pkg.sv | 25 ++
 rtl/fcmp_core.sv | 33 +++
 rtl/fcmp_pipe.sv | 106 ++++++++++
 tb/tb_fcmp_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FP definitions: compare op encodings, IEEE single field positions, S1 payload.
package fpu_pkg;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned MAG_MSB  = 30;
  localparam int unsigned OP_W     = 2;

  typedef enum logic [OP_W-1:0] {
    FCMP_EQ  = 2'b00,
    FCMP_LT  = 2'b01,
    FCMP_LE  = 2'b10,
    FCMP_RSV = 2'b11
  } fcmp_op_e;

  // Pre-decoded operand relations captured in the first pipeline stage
  typedef struct packed {
    logic sign1;
    logic sign2;
    logic mag_lt;
    logic mag_eq;
    logic bothzero;
  } fcmp_fields_t;

endpackage

// File: rtl/fcmp_core.sv
// Combinational sign-magnitude compare resolve: turns pre-decoded fields into a result bit.
module fcmp_core
  import fpu_pkg::*;
(
  input  fcmp_fields_t fields,
  input  fcmp_op_e     op,
  output logic         y_c
);

  logic lt;
  logic eq;

  // Ordering by sign pair; +0 and -0 compare equal, so mixed-sign zeros are not less-than
  always_comb begin
    lt  = 1'b0;
    eq  = 1'b0;
    y_c = 1'b0;
    case ({fields.sign1, fields.sign2})
      2'b00:   lt = fields.mag_lt;
      2'b01:   lt = 1'b0;
      2'b10:   lt = ~fields.bothzero;
      default: lt = ~fields.mag_lt & ~fields.mag_eq;
    endcase
    eq = (fields.mag_eq & (fields.sign1 == fields.sign2)) | fields.bothzero;
    case (op)
      FCMP_EQ: y_c = eq;
      FCMP_LT: y_c = lt;
      FCMP_LE: y_c = lt | eq;
      default: y_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/fcmp_pipe.sv
// Two-stage pipelined single-precision compare (feq/flt/fle) with valid/ready on both sides.
module fcmp_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [FP_W-1:0]  in_x1,
  input  logic [FP_W-1:0]  in_x2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [FP_W-1:0]  out_y
);

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic             accept;
  fcmp_fields_t     in_fields;
  fcmp_fields_t     s1_fields;
  fcmp_op_e         s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic             y_c;
  logic             s2_y;
  logic [TAG_W-1:0] s2_tag;

  // Operand pre-decode: only magnitude relations and signs are carried forward
  always_comb begin
    in_fields          = '0;
    in_fields.sign1    = in_x1[SIGN_BIT];
    in_fields.sign2    = in_x2[SIGN_BIT];
    in_fields.mag_lt   = in_x1[MAG_MSB:0] < in_x2[MAG_MSB:0];
    in_fields.mag_eq   = in_x1[MAG_MSB:0] == in_x2[MAG_MSB:0];
    in_fields.bothzero = (in_x1[MAG_MSB:0] == '0) && (in_x2[MAG_MSB:0] == '0);
  end

  // Handshake/advance: a stage moves when it is empty or the one after it moves
  always_comb begin
    s2_adv   = ~s2_valid | out_ready;
    s1_adv   = ~s1_valid | s2_adv;
    in_ready = s1_adv;
    accept   = in_valid & s1_adv;
  end

  // Stage 1 register: flush kills the valid, including a same-cycle accept
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_fields <= '0;
      s1_op     <= FCMP_EQ;
      s1_tag    <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (s1_adv) begin
        s1_valid <= accept;
      end
      if (s1_adv) begin
        s1_fields <= in_fields;
        s1_op     <= fcmp_op_e'(in_op);
        s1_tag    <= in_tag;
      end
    end
  end

  fcmp_core u_core (
    .fields (s1_fields),
    .op     (s1_op),
    .y_c    (y_c)
  );

  // Stage 2 register: holds result and tag stable while writeback stalls
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_y     <= 1'b0;
      s2_tag   <= '0;
    end else begin
      if (flush) begin
        s2_valid <= 1'b0;
      end else if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (s2_adv) begin
        s2_y   <= y_c;
        s2_tag <= s1_tag;
      end
    end
  end

  // Outputs come straight from stage 2 state
  always_comb begin
    out_valid = s2_valid;
    out_tag   = s2_tag;
    out_y     = {{(FP_W-1){1'b0}}, s2_y};
  end

endmodule

// File: tb/tb_fcmp_pipe.sv
// Scoreboard bench for fcmp_pipe: driver pushes expected results, negedge monitor checks delivery.
module tb_fcmp_pipe;

  localparam int unsigned TAG_W = 5;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             y;
  } exp_t;

  logic             clk = 1'b0;
  logic             rstn;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      in_x1;
  logic [31:0]      in_x2;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic [31:0]      out_y;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   n_acc  = 0;

  fcmp_pipe #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_y     (out_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: map sign-magnitude onto a signed integer line (+0 and -0 both land on 0)
  function automatic logic ref_y(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ka;
    longint kb;
    ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    case (op)
      2'b00:   return ka == kb;
      2'b01:   return ka < kb;
      2'b10:   return ka <= kb;
      default: return 1'b0;
    endcase
  endfunction

  // One clock of stimulus; expected in_ready comes from the count of ops in flight
  task automatic cyc(input logic v, input logic [1:0] op, input logic [TAG_W-1:0] tag,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic ordy, input logic fl);
    logic exp_rdy;
    @(posedge clk);
    #1;
    in_valid = v; in_op = op; in_tag = tag; in_x1 = a; in_x2 = b;
    out_ready = ordy; flush = fl;
    #2;
    if (rstn) begin
      exp_rdy = !(sb.size() == 2 && !ordy);
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
      if (v && exp_rdy && !fl) begin
        sb.push_back('{tag: tag, y: ref_y(op, a, b)});
        n_acc++;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 2'b00, '0, 32'h0, 32'h0, ordy, 1'b0);
  endtask

  task automatic gen_pair(output logic [31:0] a, output logic [31:0] b);
    a = $urandom;
    b = $urandom;
    case ($urandom_range(0, 5))
      0: begin a = {a[31], 31'h0}; b = {b[31], 31'h0}; end
      1: b = a;
      2: b = {~a[31], a[30:0]};
      3: begin a = {a[31], 23'h0, a[7:0]}; b = {b[31], 23'h0, b[7:0]}; end
      default: ;
    endcase
  endtask

  // Monitor: compare whatever the DUT presents against the head of the scoreboard
  always @(negedge clk) begin
    if (rstn) begin
      if (sb.size() == 0) begin
        chk("idle_out_valid", {31'b0, out_valid}, 32'h0);
      end else if (out_valid) begin
        chk("out_tag", {27'b0, out_tag}, {27'b0, sb[0].tag});
        chk("out_y", out_y, {31'b0, sb[0].y});
        if (out_ready) void'(sb.pop_front());
      end
      if (flush) sb.delete();
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          acc0;
    int          budget;

    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_tag = '0;
    in_x1 = '0; in_x2 = '0; out_ready = 1'b1;
    #13;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_y", out_y, 32'h0);
    chk("rst_out_tag", {27'b0, out_tag}, 32'h0);
    @(posedge clk); #2; rstn = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

    // Latency of a single op into an empty pipe
    cyc(1'b1, 2'b10, 5'd3, 32'h3F800000, 32'h40000000, 1'b1, 1'b0);
    idle(1'b1);
    chk("lat_edge1", {31'b0, out_valid}, 32'h0);
    idle(1'b1);
    chk("lat_edge2", {31'b0, out_valid}, 32'h1);
    chk("lat_y", out_y, 32'h1);
    chk("lat_tag", {27'b0, out_tag}, 32'd3);

    // Directed values
    cyc(1'b1, 2'b01, 5'd4, 32'h3F800000, 32'h40000000, 1'b1, 1'b0);
    cyc(1'b1, 2'b00, 5'd5, 32'h3F800000, 32'h40000000, 1'b1, 1'b0);
    for (int op = 0; op < 3; op++) begin
      cyc(1'b1, 2'(op), 5'(op), 32'h00000000, 32'h80000000, 1'b1, 1'b0);
      cyc(1'b1, 2'(op), 5'(op + 8), 32'h80000000, 32'h00000000, 1'b1, 1'b0);
    end
    cyc(1'b1, 2'b00, 5'd20, 32'hBF800000, 32'hBF800000, 1'b1, 1'b0);
    cyc(1'b1, 2'b01, 5'd21, 32'hBF800000, 32'hBF800000, 1'b1, 1'b0);
    cyc(1'b1, 2'b01, 5'd22, 32'hC0000000, 32'hBF800000, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Back-to-back stream of 8
    for (int i = 0; i < 8; i++) begin
      gen_pair(a, b);
      cyc(1'b1, 2'($urandom_range(0, 2)), 5'(i), a, b, 1'b1, 1'b0);
    end
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Backpressure: 4 cycles of issue with writeback stalled
    acc0 = n_acc;
    for (int i = 0; i < 4; i++) begin
      gen_pair(a, b);
      cyc(1'b1, 2'b10, 5'(16 + i), a, b, 1'b0, 1'b0);
    end
    chk("bp_accepted", 32'(n_acc - acc0), 32'd2);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Flush with both stages full and an issue in the same cycle
    cyc(1'b1, 2'b01, 5'd24, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 5'd25, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 5'd26, 32'h3F800000, 32'h40000000, 1'b0, 1'b1);
    idle(1'b1);
    chk("flush_out_valid", {31'b0, out_valid}, 32'h0);
    cyc(1'b1, 2'b10, 5'd27, 32'h40000000, 32'h3F800000, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Asynchronous reset in the middle of a stream
    for (int i = 0; i < 3; i++) begin
      gen_pair(a, b);
      cyc(1'b1, 2'b10, 5'(i), a, b, 1'b0, 1'b0);
    end
    @(posedge clk); #2;
    rstn = 1'b0;
    in_valid = 1'b0; flush = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("arst_out_y", out_y, 32'h0);
    chk("arst_out_tag", {27'b0, out_tag}, 32'h0);
    sb.delete();
    @(posedge clk); @(posedge clk); #2;
    rstn = 1'b1;
    #1;
    chk("arst_in_ready", {31'b0, in_ready}, 32'h1);
    cyc(1'b1, 2'b11, 5'd9, 32'h00000000, 32'h80000000, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Randomized traffic with random backpressure and occasional flush
    for (int i = 0; i < 1500; i++) begin
      gen_pair(a, b);
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 5'($urandom),
          a, b, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));
    end

    // Drain with a bounded wait
    budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      idle(1'b1);
      budget++;
    end
    idle(1'b1);
    chk("drain_left", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
